// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared types and constants for the load/store unit.
//   lsu_funct3_e : RISC-V load/store width encodings (funct3)
//   lsu_region_e : decoded target of an access
//   lsu_state_e  : handshake FSM states
//   lsu_size_e   : access width derived from funct3
//   IO_OFF_*     : register offsets inside the output-register window
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_funct3_e;

    typedef enum logic [1:0] {
        REG_DMEM = 2'd0,
        REG_IO   = 2'd1,
        REG_SW   = 2'd2,
        REG_NONE = 2'd3
    } lsu_region_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    localparam logic [15:0] IO_OFF_LEDR = 16'h0000;
    localparam logic [15:0] IO_OFF_LEDG = 16'h0010;
    localparam logic [15:0] IO_OFF_HEX  = 16'h0020;
    localparam logic [15:0] IO_OFF_LCD  = 16'h0030;

    // Undefined funct3 encodings behave as full-word accesses.
    function automatic lsu_size_e lsu_size(input logic [2:0] f3);
        case (f3)
            LSU_B, LSU_BU: return SZ_B;
            LSU_H, LSU_HU: return SZ_H;
            default:       return SZ_W;
        endcase
    endfunction

    function automatic logic lsu_unsigned(input logic [2:0] f3);
        return (f3 == LSU_BU) || (f3 == LSU_HU);
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// lsu_data_align -- combinational lane steering for the load/store unit.
//   Store side: i_acc_funct3/i_acc_addr/i_st_data -> o_st_be (byte enables),
//               o_st_wdata (store data replicated onto its lanes), o_misalign.
//   Load side : i_ld_funct3/i_ld_addr/i_ld_word -> o_ld_data (lane extract,
//               sign- or zero-extended).
//   Build option LSU_MISALIGN_CHK_EN: when defined, misaligned H/W accesses
//   raise o_misalign; otherwise the low address bits are ignored for alignment.
module lsu_data_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_acc_funct3,
    input  logic [1:0]  i_acc_addr,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_wdata,
    output logic        o_misalign,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_addr,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Store byte enables, lane replication and alignment check.
    always_comb begin
        o_st_be    = 4'b1111;
        o_st_wdata = i_st_data;
        o_misalign = 1'b0;
        case (lsu_size(i_acc_funct3))
            SZ_B: begin
                o_st_be    = 4'b0001 << i_acc_addr;
                o_st_wdata = {4{i_st_data[7:0]}};
            end
            SZ_H: begin
                o_st_be    = i_acc_addr[1] ? 4'b1100 : 4'b0011;
                o_st_wdata = {2{i_st_data[15:0]}};
            end
            default: begin
                o_st_be    = 4'b1111;
                o_st_wdata = i_st_data;
            end
        endcase
`ifdef LSU_MISALIGN_CHK_EN
        case (lsu_size(i_acc_funct3))
            SZ_B:    o_misalign = 1'b0;
            SZ_H:    o_misalign = i_acc_addr[0];
            default: o_misalign = |i_acc_addr;
        endcase
`endif
    end

    // Load lane extraction and extension.
    always_comb begin
        ld_byte_s = 8'(i_ld_word >> {i_ld_addr, 3'b000});
        ld_half_s = i_ld_addr[1] ? i_ld_word[31:16] : i_ld_word[15:0];
        case (lsu_size(i_ld_funct3))
            SZ_B: begin
                if (lsu_unsigned(i_ld_funct3)) o_ld_data = {24'h000000, ld_byte_s};
                else                           o_ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
            end
            SZ_H: begin
                if (lsu_unsigned(i_ld_funct3)) o_ld_data = {16'h0000, ld_half_s};
                else                           o_ld_data = {{16{ld_half_s[15]}}, ld_half_s};
            end
            default: o_ld_data = i_ld_word;
        endcase
    end

endmodule

// File: rtl/lsu_mmio_ctrl.sv
// lsu_mmio_ctrl -- load/store unit between the core MEM stage and board I/O.
//   i_clk, i_rst (sync, active-high)
//   i_req/i_wren/i_funct3/i_addr/i_st_data : access request held until o_ack
//   i_io_sw   : asynchronous switches, 2-flop synchronised
//   o_ack     : one-cycle completion pulse, one cycle after accept
//   o_stall   : i_req & ~o_ack
//   o_err     : with o_ack, unmapped/illegal access
//   o_ld_data : extended load result, valid with o_ack on loads
//   o_io_ledr/o_io_ledg/o_io_hex/o_io_lcd : memory-mapped output registers
//   Build option LSU_MISALIGN_CHK_EN (see lsu_data_align) turns misaligned
//   H/W accesses into error completions.
module lsu_mmio_ctrl
    import lsu_pkg::*;
#(
    parameter int          DMEM_AW   = 11,
    parameter logic [15:0] DMEM_BASE = 16'h2000,
    parameter int          NUM_HEX   = 8,
    parameter logic [15:0] IO_BASE   = 16'h7000,
    parameter logic [15:0] SW_ADDR   = 16'h7800
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req,
    input  logic                 i_wren,
    input  logic [2:0]           i_funct3,
    input  logic [31:0]          i_addr,
    input  logic [31:0]          i_st_data,
    input  logic [31:0]          i_io_sw,
    output logic                 o_ack,
    output logic                 o_stall,
    output logic                 o_err,
    output logic [31:0]          o_ld_data,
    output logic [31:0]          o_io_ledr,
    output logic [31:0]          o_io_ledg,
    output logic [7*NUM_HEX-1:0] o_io_hex,
    output logic [31:0]          o_io_lcd
);

    localparam int          NUM_HREG   = NUM_HEX / 4;
    // io_q layout: [0]=LEDR, [1]=LEDG, [2..]=HEX, [last]=LCD
    localparam int          NUM_IO     = NUM_HREG + 3;
    localparam int          IO_IW      = $clog2(NUM_IO);
    localparam logic [31:0] DMEM_BYTES = 32'(4 * (2 ** DMEM_AW));

    lsu_state_e  state_q, state_d;
    lsu_region_e region_q, region_d, region_s;
    logic        ack_q, ack_d, err_q, err_d, wren_q, wren_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  alo_q, alo_d;
    logic [31:0] io_rd_q, io_rd_d, sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic [31:0] io_q [NUM_IO];
    logic [31:0] io_d [NUM_IO];
    logic [31:0] dmem [2**DMEM_AW];
    logic [31:0] dmem_rd_q;

    logic [15:0]        addr16_s, io_off_s, hex_off_s;
    logic [31:0]        dm_off_s, st_wdata_s, ld_word_s, ld_ext_s;
    logic [DMEM_AW-1:0] dm_widx_s;
    logic [IO_IW-1:0]   io_idx_s;
    logic [3:0]         st_be_s;
    logic               misalign_s, accept_s, err_s, dm_we_s, unused_s;

    assign addr16_s  = i_addr[15:0];
    // Offsets wrap for addresses below a base, so they fall outside every window.
    assign dm_off_s  = {16'h0000, addr16_s} - {16'h0000, DMEM_BASE};
    assign io_off_s  = addr16_s - IO_BASE;
    assign hex_off_s = io_off_s - IO_OFF_HEX;
    assign dm_widx_s = dm_off_s[DMEM_AW+1:2];
    assign unused_s  = ^{i_addr[31:16], io_off_s[1:0], hex_off_s[1:0]};

    // Address decode: switch word first, then DMEM, then individual IO registers.
    always_comb begin
        region_s = REG_NONE;
        io_idx_s = '0;
        if (addr16_s[15:2] == SW_ADDR[15:2]) begin
            region_s = REG_SW;
        end else if (dm_off_s < DMEM_BYTES) begin
            region_s = REG_DMEM;
        end else if (io_off_s[15:2] == IO_OFF_LEDR[15:2]) begin
            region_s = REG_IO;
            io_idx_s = IO_IW'(0);
        end else if (io_off_s[15:2] == IO_OFF_LEDG[15:2]) begin
            region_s = REG_IO;
            io_idx_s = IO_IW'(1);
        end else if ((io_off_s >= IO_OFF_HEX) && (io_off_s < IO_OFF_HEX + 16'(4 * NUM_HREG))) begin
            region_s = REG_IO;
            io_idx_s = IO_IW'(hex_off_s[15:2]) + IO_IW'(2);
        end else if (io_off_s[15:2] == IO_OFF_LCD[15:2]) begin
            region_s = REG_IO;
            io_idx_s = IO_IW'(NUM_IO - 1);
        end else begin
            region_s = REG_NONE;
        end
    end

    lsu_data_align u_align (
        .i_acc_funct3 (i_funct3),
        .i_acc_addr   (i_addr[1:0]),
        .i_st_data    (i_st_data),
        .o_st_be      (st_be_s),
        .o_st_wdata   (st_wdata_s),
        .o_misalign   (misalign_s),
        .i_ld_funct3  (f3_q),
        .i_ld_addr    (alo_q),
        .i_ld_word    (ld_word_s),
        .o_ld_data    (ld_ext_s)
    );

    assign accept_s = (state_q == ST_IDLE) && i_req;
    assign err_s    = (region_s == REG_NONE) || ((region_s == REG_SW) && i_wren) || misalign_s;
    assign dm_we_s  = accept_s && i_wren && (region_s == REG_DMEM) && !err_s && !i_rst;

    // Next-state: handshake FSM, access capture, IO register writes, synchroniser.
    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        wren_d    = wren_q;
        f3_d      = f3_q;
        alo_d     = alo_q;
        region_d  = region_q;
        io_rd_d   = io_rd_q;
        io_d      = io_q;
        sw_meta_d = i_io_sw;
        sw_sync_d = sw_meta_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d  = ST_BUSY;
                    ack_d    = 1'b1;
                    err_d    = err_s;
                    wren_d   = i_wren;
                    f3_d     = i_funct3;
                    alo_d    = i_addr[1:0];
                    region_d = region_s;
                    if (region_s == REG_SW)      io_rd_d = sw_sync_q;
                    else if (region_s == REG_IO) io_rd_d = io_q[io_idx_s];
                    else                         io_rd_d = 32'h00000000;
                    if (i_wren && (region_s == REG_IO) && !err_s) begin
                        for (int b = 0; b < 4; b++) begin
                            if (st_be_s[b]) io_d[io_idx_s][8*b +: 8] = st_wdata_s[8*b +: 8];
                            else            io_d[io_idx_s][8*b +: 8] = io_q[io_idx_s][8*b +: 8];
                        end
                    end else begin
                        io_d = io_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control/IO/synchroniser registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            wren_q    <= 1'b0;
            f3_q      <= 3'b000;
            alo_q     <= 2'b00;
            region_q  <= REG_NONE;
            io_rd_q   <= 32'h00000000;
            sw_meta_q <= 32'h00000000;
            sw_sync_q <= 32'h00000000;
            for (int i = 0; i < NUM_IO; i++) io_q[i] <= 32'h00000000;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            wren_q    <= wren_d;
            f3_q      <= f3_d;
            alo_q     <= alo_d;
            region_q  <= region_d;
            io_rd_q   <= io_rd_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            io_q      <= io_d;
        end
    end

    // DMEM: byte-enable write and synchronous read on the accept edge; never reset.
    always_ff @(posedge i_clk) begin
        if (dm_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be_s[b]) dmem[dm_widx_s][8*b +: 8] <= st_wdata_s[8*b +: 8];
            end
        end
        if (accept_s) dmem_rd_q <= dmem[dm_widx_s];
    end

    assign ld_word_s = (region_q == REG_DMEM) ? dmem_rd_q : io_rd_q;

    // Load result is forced to zero outside a successful load completion.
    always_comb begin
        if (ack_q && !wren_q && !err_q) o_ld_data = ld_ext_s;
        else                            o_ld_data = 32'h00000000;
    end

    assign o_ack     = ack_q;
    assign o_err     = err_q;
    assign o_stall   = i_req && !ack_q;
    assign o_io_ledr = io_q[0];
    assign o_io_ledg = io_q[1];
    assign o_io_lcd  = io_q[NUM_IO-1];

    for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
        assign o_io_hex[7*k +: 7] = io_q[2 + k/4][8*(k%4) +: 7];
    end

endmodule

// File: tb/tb_lsu_mmio_ctrl.sv
// tb_lsu_mmio_ctrl -- directed and randomized bench for lsu_mmio_ctrl.
// The reference model is a flat byte-addressed map of every writable location
// (DMEM bytes and IO register bytes) plus the last switch value.
module tb_lsu_mmio_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst, i_req, i_wren;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_st_data, i_io_sw;
    logic        o_ack, o_stall, o_err;
    logic [31:0] o_ld_data, o_io_ledr, o_io_ledg, o_io_lcd;
    logic [55:0] o_io_hex;

    lsu_mmio_ctrl dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (i_req),
        .i_wren    (i_wren),
        .i_funct3  (i_funct3),
        .i_addr    (i_addr),
        .i_st_data (i_st_data),
        .i_io_sw   (i_io_sw),
        .o_ack     (o_ack),
        .o_stall   (o_stall),
        .o_err     (o_err),
        .o_ld_data (o_ld_data),
        .o_io_ledr (o_io_ledr),
        .o_io_ledg (o_io_ledg),
        .o_io_hex  (o_io_hex),
        .o_io_lcd  (o_io_lcd)
    );

    always #5 i_clk = ~i_clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [7:0]  mem_m [int];
    logic [31:0] sw_m = 32'h00000000;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] io_word(input int w);
        logic [31:0] v;
        v = 32'h00000000;
        for (int i = 0; i < 4; i++) begin
            if (mem_m.exists(w + i)) v[8*i +: 8] = mem_m[w + i];
        end
        return v;
    endfunction

    // Reference: decides error/load result and applies committed stores to the map.
    task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, output logic e_err, output logic [31:0] e_ld);
        int a, size, base, w;
        logic uns, mis, is_sw, is_dm, is_io;
        logic [31:0] val;
        logic [7:0] b;
        a    = int'(addr[15:0]);
        size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 4);
        uns  = (f3 == 3'd4) || (f3 == 3'd5);
        base = a - (a % size);
        w    = a - (a % 4);
`ifdef LSU_MISALIGN_CHK_EN
        mis = (a % size) != 0;
`else
        mis = 1'b0;
`endif
        is_sw = (w == 32'h7800);
        is_dm = (a >= 32'h2000) && (a < 32'h4000);
        is_io = (w == 32'h7000) || (w == 32'h7010) || (w == 32'h7020) || (w == 32'h7024) || (w == 32'h7030);
        e_err = !(is_sw || is_dm || is_io) || (is_sw && wr) || mis;
        e_ld  = 32'h00000000;
        if (!e_err && wr) begin
            for (int i = 0; i < size; i++) mem_m[base + i] = data[8*i +: 8];
        end else if (!e_err) begin
            val = 32'h00000000;
            for (int i = 0; i < size; i++) begin
                if (is_sw)                       b = sw_m[8*((base + i) % 4) +: 8];
                else if (mem_m.exists(base + i)) b = mem_m[base + i];
                else                             b = 8'h00;
                val = val | (32'(b) << (8*i));
            end
            if (size == 1 && !uns) val = {{24{val[7]}}, val[7:0]};
            if (size == 2 && !uns) val = {{16{val[15]}}, val[15:0]};
            e_ld = val;
        end
    endtask

    task automatic do_access(input string tag, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] data, output logic [31:0] ld_obs);
        logic e_err;
        logic [31:0] e_ld;
        int waited;
        model(wr, f3, addr, data, e_err, e_ld);
        @(negedge i_clk);
        i_req = 1'b1; i_wren = wr; i_funct3 = f3; i_addr = addr; i_st_data = data;
        #1;
        check({tag, "_stall_wait"}, 64'(o_stall), 64'd1);
        @(posedge i_clk); #1;
        waited = 0;
        while (o_ack !== 1'b1 && waited < 4) begin
            @(posedge i_clk); #1;
            waited++;
        end
        check({tag, "_ack"}, 64'(o_ack), 64'd1);
        check({tag, "_latency"}, 64'(waited), 64'd0);
        check({tag, "_err"}, 64'(o_err), 64'(e_err));
        check({tag, "_stall_ack"}, 64'(o_stall), 64'd0);
        if (!wr) check({tag, "_ld"}, 64'(o_ld_data), 64'(e_ld));
        ld_obs = o_ld_data;
        @(negedge i_clk);
        i_req = 1'b0; i_wren = 1'b0;
    endtask

    task automatic check_io(input string tag);
        logic [55:0] hx;
        logic [31:0] t;
        for (int k = 0; k < 8; k++) begin
            t = io_word(32'h7020 + 4*(k/4));
            hx[7*k +: 7] = t[8*(k%4) +: 7];
        end
        check({tag, "_ledr"}, 64'(o_io_ledr), 64'(io_word(32'h7000)));
        check({tag, "_ledg"}, 64'(o_io_ledg), 64'(io_word(32'h7010)));
        check({tag, "_lcd"},  64'(o_io_lcd),  64'(io_word(32'h7030)));
        check({tag, "_hex"},  64'(o_io_hex),  64'(hx));
    endtask

    task automatic set_sw(input logic [31:0] v);
        @(negedge i_clk);
        i_io_sw = v; sw_m = v;
        repeat (3) @(posedge i_clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] ld;
        logic [31:0] ra;
        int cat;
        int io_b [5]  = '{32'h7000, 32'h7010, 32'h7020, 32'h7024, 32'h7030};
        int rsv_b [5] = '{32'h7004, 32'h7014, 32'h7028, 32'h7034, 32'h7040};
        int unm_b [4] = '{32'h5000, 32'h1FFC, 32'h4000, 32'h0000};

        i_rst = 1'b1; i_req = 1'b0; i_wren = 1'b0; i_funct3 = 3'd0;
        i_addr = 32'h0; i_st_data = 32'h0; i_io_sw = 32'h0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_ack", 64'(o_ack), 64'd0);
        check("rst_err", 64'(o_err), 64'd0);
        check("rst_ld",  64'(o_ld_data), 64'd0);
        check_io("rst");
        @(negedge i_clk);
        i_rst = 1'b0;

        do_access("sw_dead", 1'b1, 3'd2, 32'h0000_2004, 32'hDEADBEEF, ld);
        do_access("lw_dead", 1'b0, 3'd2, 32'h0000_2004, 32'h0, ld);
        check("lw_dead_const", 64'(ld), 64'hDEADBEEF);
        @(posedge i_clk); #1;
        check("ack_pulse_drop", 64'(o_ack), 64'd0);

        do_access("sw_zero", 1'b1, 3'd2, 32'h0000_2004, 32'h0, ld);
        do_access("sb_7f",   1'b1, 3'd0, 32'h0000_2005, 32'h0000_007F, ld);
        do_access("lb_7f",   1'b0, 3'd0, 32'h0000_2005, 32'h0, ld);
        check("lb_7f_const", 64'(ld), 64'h0000007F);
        do_access("sb_80",   1'b1, 3'd0, 32'h0000_2005, 32'h0000_0080, ld);
        do_access("lb_80",   1'b0, 3'd0, 32'h0000_2005, 32'h0, ld);
        check("lb_80_const", 64'(ld), 64'hFFFFFF80);
        do_access("lbu_80",  1'b0, 3'd4, 32'h0000_2005, 32'h0, ld);
        check("lbu_80_const", 64'(ld), 64'h00000080);

        do_access("sh_hex",  1'b1, 3'd1, 32'h0000_7022, 32'h0000_ABCD, ld);
        check("hex_d2", 64'(o_io_hex[14 +: 7]), 64'h4D);
        check("hex_d3", 64'(o_io_hex[21 +: 7]), 64'h2B);
        do_access("lw_hex",  1'b0, 3'd2, 32'h0000_7020, 32'h0, ld);
        check("lw_hex_const", 64'(ld), 64'hABCD0000);

        set_sw(32'h0000_1234);
        do_access("lw_sw", 1'b0, 3'd2, 32'h0000_7800, 32'h0, ld);
        check("lw_sw_const", 64'(ld), 64'h00001234);
        do_access("sw_sw", 1'b1, 3'd2, 32'h0000_7800, 32'hFFFF_FFFF, ld);
        check_io("after_sw_store");
        do_access("lw_unm", 1'b0, 3'd2, 32'h0000_5000, 32'h0, ld);

        do_access("sw_2000", 1'b1, 3'd2, 32'h0000_2000, 32'h1111_2222, ld);
        do_access("sw_mis",  1'b1, 3'd2, 32'h0000_2002, 32'h3333_4444, ld);
        do_access("lw_2000", 1'b0, 3'd2, 32'h0000_2000, 32'h0, ld);

        // Reset while BUSY: the store is committed, IO registers are cleared.
        do_access("sw_ledr", 1'b1, 3'd2, 32'h0000_7000, 32'h55AA_55AA, ld);
        check_io("pre_rst");
        model(1'b1, 3'd2, 32'h0000_2010, 32'hCAFE_F00D, ld[0], ra);
        @(negedge i_clk);
        i_req = 1'b1; i_wren = 1'b1; i_funct3 = 3'd2; i_addr = 32'h0000_2010; i_st_data = 32'hCAFE_F00D;
        @(posedge i_clk); #1;
        check("rst_busy_ack", 64'(o_ack), 64'd1);
        @(negedge i_clk);
        i_rst = 1'b1; i_req = 1'b0; i_wren = 1'b0;
        @(posedge i_clk); #1;
        for (int a = 32'h7000; a < 32'h7040; a++) begin
            if (mem_m.exists(a)) mem_m.delete(a);
        end
        check("rst_busy_noack", 64'(o_ack), 64'd0);
        check("rst_busy_err",   64'(o_err), 64'd0);
        check_io("rst_busy");
        check("rst_busy_ledr0", 64'(o_io_ledr), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        do_access("lw_kept", 1'b0, 3'd2, 32'h0000_2010, 32'h0, ld);
        check("lw_kept_const", 64'(ld), 64'hCAFEF00D);

        // Randomized phase over a pre-filled DMEM slice, IO, switch and holes.
        for (int w = 0; w < 16; w++) begin
            do_access("fill", 1'b1, 3'd2, 32'h2000 + 4*w, $urandom, ld);
        end
        for (int it = 0; it < 150; it++) begin
            if (it % 10 == 0) set_sw($urandom);
            cat = $urandom_range(0, 9);
            if (cat <= 4)      ra = 32'h2000 + $urandom_range(0, 63);
            else if (cat <= 6) ra = io_b[$urandom_range(0, 4)] + $urandom_range(0, 3);
            else if (cat == 7) ra = 32'h7800 + $urandom_range(0, 3);
            else if (cat == 8) ra = rsv_b[$urandom_range(0, 4)];
            else               ra = unm_b[$urandom_range(0, 3)];
            ra[31:16] = 16'($urandom);
            do_access("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, ld);
        end
        check_io("rnd_end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
